// File: rtl/step_pulse_gen.sv
// step_pulse_gen: step-pulse source for the pedometer. Emits one-cycle step
// pulses at a mode-selected rate and publishes a one-second tick plus an
// elapsed-seconds index as a shared time base.
//
// Optional feature macro: STEP_GEN_HYBRID_EN compiles in the hybrid workout
// schedule for MODE=11. Without it MODE=11 yields rate 0 and DONE stays 0.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RESET     in   synchronous active-high reset
//   START     in   1 = generate, 0 = idle and clear run state
//   MODE[1:0] in   00 walk(32/s) 01 jog(64/s) 10 run(128/s) 11 hybrid
//   PULSE     out  registered one-cycle step pulse
//   SEC_TICK  out  registered one-cycle pulse at each second boundary
//   SEC_IDX   out  elapsed whole seconds since START, saturating at 255
//   DONE      out  hybrid selected and SEC_IDX >= 144
module step_pulse_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] MODE,
    output logic       PULSE,
    output logic       SEC_TICK,
    output logic [7:0] SEC_IDX,
    output logic       DONE
);

    localparam int unsigned CYC_W = $clog2(CLK_HZ);
    // One spare bit so acc + rate never wraps (rate < CLK_HZ).
    localparam int unsigned ACC_W = $clog2(CLK_HZ) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_HZ - 1);
    localparam logic [ACC_W-1:0] ACC_HZ   = ACC_W'(CLK_HZ);
    localparam logic [7:0]       DONE_SEC = 8'd144;

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       sec_q, sec_d;
    logic             pulse_q, pulse_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic [7:0]       rate_c;
    logic [ACC_W-1:0] sum_c;

`ifdef STEP_GEN_HYBRID_EN
    // Hybrid workout schedule: steps per second as a function of elapsed second.
    function automatic logic [7:0] hybrid_rate(input logic [7:0] s);
        logic [7:0] r;
        r = 8'd0;
        if (s <= 8'd8) begin
            case (s)
                8'd0:    r = 8'd20;
                8'd1:    r = 8'd33;
                8'd2:    r = 8'd66;
                8'd3:    r = 8'd27;
                8'd4:    r = 8'd70;
                8'd5:    r = 8'd30;
                8'd6:    r = 8'd19;
                8'd7:    r = 8'd30;
                default: r = 8'd33;
            endcase
        end else if (s <= 8'd72) begin
            r = 8'd69;
        end else if (s <= 8'd78) begin
            r = 8'd34;
        end else if (s <= 8'd143) begin
            r = 8'd124;
        end else begin
            r = 8'd0;
        end
        return r;
    endfunction
`endif

    // Rate selection from MODE and the current second.
    always_comb begin
        rate_c = 8'd0;
        case (MODE)
            2'b00:   rate_c = 8'd32;
            2'b01:   rate_c = 8'd64;
            2'b10:   rate_c = 8'd128;
            default: begin
`ifdef STEP_GEN_HYBRID_EN
                rate_c = hybrid_rate(sec_q);
`else
                rate_c = 8'd0;
`endif
            end
        endcase
    end

    // Accumulator, cycle/second counters and next-output computation.
    always_comb begin
        cyc_d   = cyc_q;
        acc_d   = acc_q;
        sec_d   = sec_q;
        pulse_d = 1'b0;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        sum_c   = acc_q + ACC_W'(rate_c);

        if (!START) begin
            cyc_d = '0;
            acc_d = '0;
            sec_d = '0;
        end else begin
            if (sum_c >= ACC_HZ) begin
                pulse_d = 1'b1;
                acc_d   = sum_c - ACC_HZ;
            end else begin
                acc_d   = sum_c;
            end
            // Boundary clears acc after the pulse decision so each second
            // at constant rate yields exactly rate pulses.
            if (cyc_q == CYC_LAST) begin
                cyc_d  = '0;
                tick_d = 1'b1;
                acc_d  = '0;
                if (sec_q != 8'hFF) begin
                    sec_d = sec_q + 8'd1;
                end
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end
        end

`ifdef STEP_GEN_HYBRID_EN
        // Based on the next second so DONE rises on the edge sec reaches 144.
        done_d = (MODE == 2'b11) && (sec_d >= DONE_SEC);
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cyc_q   <= '0;
            acc_q   <= '0;
            sec_q   <= '0;
            pulse_q <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            sec_q   <= sec_d;
            pulse_q <= pulse_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign PULSE    = pulse_q;
    assign SEC_TICK = tick_q;
    assign SEC_IDX  = sec_q;
    assign DONE     = done_q;

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Step-pulse source for the fitbit pedometer: emits one-cycle step pulses at a mode-selected rate (walk, jog, run, or a fixed hybrid workout schedule), for the fitbit step counter to consume. Sits upstream of the fitbit core on the same `CLK`. Also publishes a one-second tick and an elapsed-seconds index so the counter and display logic share one time base.

## Interface
- `CLK_HZ`, default 100_000_000, `CLK` frequency in Hz; also the number of cycles per second. Must be >= 256. Benches use 1000.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  1 = generate; 0 = idle and clear run state.
- `MODE`  in  2  00 walk (32 steps/s), 01 jog (64), 10 run (128), 11 hybrid schedule.
- `PULSE`  out  1  registered, one-cycle-high step pulse.
- `SEC_TICK`  out  1  registered, one-cycle-high at each second boundary.
- `SEC_IDX`  out  8  elapsed whole seconds since `START`; saturates at 255.
- `DONE`  out  1  high while hybrid is selected and `SEC_IDX` >= 144.

## Operation
- Datapath:
  - cycle counter `cyc` (0..CLK_HZ-1).
  - rate `R` (8 bits, 0..128).
  - accumulator `acc` (width clog2(CLK_HZ)+1).
  - second counter `sec` (8 bits), which drives `SEC_IDX`.
- `R` is combinational from `MODE` and `sec`, sampled every cycle.
- Hybrid rate `R` by `sec`:
  - 0:20, 1:33, 2:66, 3:27, 4:70, 5:30, 6:19, 7:30, 8:33.
  - 9–72: 69.
  - 73–78: 34.
  - 79–143: 124.
  - >= 144: 0.
- Every edge with `START`=1 and `RESET`=0:
  - sum = acc + R.
  - If sum >= CLK_HZ: `PULSE`<=1 and acc<=sum-CLK_HZ.
  - Otherwise: `PULSE`<=0 and acc<=sum.
  - Since R < CLK_HZ/2, there is at most one pulse per edge and never two consecutive pulses.
- Second boundary (cyc == CLK_HZ-1):
  - cyc<=0, `SEC_TICK`<=1, sec<=sec+1 (saturating at 255).
  - acc<=0, applied after that edge's pulse decision.
  - Consequence: a full second at constant R yields exactly R pulses. The last pulse lands on the boundary edge.
  - At all other edges cyc increments and `SEC_TICK`<=0.
- `START`=0:
  - cyc, acc, sec <= 0.
  - `PULSE`, `SEC_TICK` <= 0.
  - The next `START`=1 restarts from second 0.
- `MODE` change mid-second: the new R applies from the next edge; acc and sec are kept. Such a partial second does not guarantee an exact count.
- `DONE` = (MODE==11) && (sec >= 144), registered. After 144 s hybrid produces no pulses, but ticks continue.

## Timing
- Reset values: `PULSE`=0, `SEC_TICK`=0, `SEC_IDX`=0, `DONE`=0; all internal counters 0.
- `RESET` has priority over `START` on the same edge.
- Reset mid-run: all outputs are 0 after that edge, and counting restarts when `RESET` falls.
- With acc=0, the first pulse occurs at edge ceil(CLK_HZ/R) after `START` rises. Example: CLK_HZ=1000, walk → edge 32.
- `SEC_TICK` is high during the cycle after edge CLK_HZ, counting from `START` rising.
- `SEC_IDX` updates on that same edge.
- The pulse and tick may coincide on the boundary edge; both are reported.
- `DONE` rises on the edge where `sec` becomes 144.

## Configuration
- `STEP_GEN_HYBRID_EN` defined: the hybrid schedule lookup is compiled in, and `MODE`=11 behaves as above.
- Undefined: the schedule logic is omitted.
  - `MODE`=11 gives R=0, so no pulses.
  - `DONE` is tied to 0.
  - `SEC_TICK` and `SEC_IDX` still run.

## Test plan
All scenarios use CLK_HZ=1000.
- Reset, then `START`=1, `MODE`=00 for 1000 edges → 32 pulses, first at edge 32, last coincident with `SEC_TICK`; `SEC_IDX`=1.
- `MODE`=10 for 3000 edges → 128 pulses in each second (384 total), never two adjacent high cycles; `SEC_IDX`=3.
- Macro defined, `MODE`=11 for 150 s → per-second counts match the schedule, 13008 pulses total. `DONE` rises at `SEC_IDX`=144, with zero pulses afterwards.
- `START` dropped at edge 500 of the first second → `PULSE`, `SEC_TICK`, `SEC_IDX` = 0 after that edge. Re-raising `START` in walk mode gives the first pulse 32 edges later.
- `RESET` asserted with `START`=1 mid-second in jog mode → all outputs 0 next cycle. After release, exactly 64 pulses occur in the next full second.
- Macro undefined, `MODE`=11 for 2 s → 0 pulses, `DONE`=0, two `SEC_TICK` pulses, `SEC_IDX`=2.
